// File: rtl/gates_self_checker.sv
// gates_self_checker: drives the two-input gate set through its truth table,
// compares the returned gate outputs and reports pass/fail with diagnostics.
// Optional feature macro: GATES_CHK_STOP_ON_FAIL_EN (end the run at the first
// failing compare, holding the failing vector on a_o/b_o).
module gates_self_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  input  logic [6:0] res_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] first_fail_vec,
  output logic [6:0] first_fail_mask
);

  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned PASS_W   = 8;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned RES_W    = 7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          idx, idx_nxt;
  logic [PASS_W-1:0]   pass_cnt, pass_cnt_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
  logic                busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0]    err_nxt, err_upd;
  logic [1:0]          ffv_nxt;
  logic [RES_W-1:0]    ffm_nxt;
  logic [RES_W-1:0]    expected, mism;
  logic                va, vb, sample, last, fail;

  // Operands come straight from the registered vector index.
  assign a_o = idx[1];
  assign b_o = idx[0];

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      idx             <= 2'b00;
      pass_cnt        <= '0;
      settle_cnt      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= 2'b00;
      first_fail_mask <= '0;
    end else begin
      state           <= state_nxt;
      idx             <= idx_nxt;
      pass_cnt        <= pass_cnt_nxt;
      settle_cnt      <= settle_cnt_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      pass            <= pass_nxt;
      err_count       <= err_nxt;
      first_fail_vec  <= ffv_nxt;
      first_fail_mask <= ffm_nxt;
    end
  end

  // Next-state, compare and result update logic.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    pass_cnt_nxt   = pass_cnt;
    settle_cnt_nxt = settle_cnt;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    err_nxt        = err_count;
    ffv_nxt        = first_fail_vec;
    ffm_nxt        = first_fail_mask;
    err_upd        = err_count;

    va       = idx[1];
    vb       = idx[0];
    expected = {~(va ^ vb), va ^ vb, ~(va & vb), ~(va | vb), va | vb, va & vb, ~va};
    mism     = res_i ^ expected;
    fail     = |mism;
    sample   = (settle_cnt == SETTLE_W'(SETTLE_CYCLES));
    last     = (idx == 2'b11) && (pass_cnt == PASS_W'(PASSES - 1));

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt      = S_RUN;
          idx_nxt        = 2'b00;
          pass_cnt_nxt   = '0;
          settle_cnt_nxt = '0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          err_nxt        = '0;
          ffv_nxt        = 2'b00;
          ffm_nxt        = '0;
        end
      end
      S_RUN: begin
        if (!sample) begin
          settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
        end else begin
          settle_cnt_nxt = '0;
          if (fail) begin
            err_upd = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_W'(1);
            if (err_count == '0) begin
              ffv_nxt = idx;
              ffm_nxt = mism;
            end
          end
          err_nxt = err_upd;
`ifdef GATES_CHK_STOP_ON_FAIL_EN
          if (fail) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b0;
          end else
`endif
          if (last) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_upd == '0);
          end else begin
            idx_nxt = idx + 2'd1;
            if (idx == 2'b11) begin
              pass_cnt_nxt = pass_cnt + PASS_W'(1);
            end
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gates_self_checker.sv
// Directed bench for gates_self_checker: a gate model with an injectable
// XOR stuck-at-0 fault feeds the default instance; a second instance
// (PASSES=100, SETTLE_CYCLES=0) sees all-zero results.
module tb_gates_self_checker;

  localparam int unsigned LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst_n, start, start2;
  logic       a, b, busy, done, pass;
  logic [6:0] res, ffm;
  logic [7:0] errc;
  logic [1:0] ffv;
  logic       a2, b2, busy2, done2, pass2;
  logic [6:0] res2, ffm2;
  logic [7:0] errc2;
  logic [1:0] ffv2;
  logic       xor_stuck;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
    logic busy;
    logic done;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  gates_self_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a), .b_o(b), .res_i(res),
    .busy(busy), .done(done), .pass(pass), .err_count(errc),
    .first_fail_vec(ffv), .first_fail_mask(ffm)
  );

  gates_self_checker #(.SETTLE_CYCLES(0), .PASSES(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_o(a2), .b_o(b2), .res_i(res2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(errc2),
    .first_fail_vec(ffv2), .first_fail_mask(ffm2)
  );

  function automatic logic [6:0] gates(input logic x, input logic y, input logic stuck);
    logic [6:0] r;
    r[0] = !x;
    r[1] = x && y;
    r[2] = x || y;
    r[3] = !(x || y);
    r[4] = !(x && y);
    r[5] = (x != y) && !stuck;
    r[6] = (x == y);
    return r;
  endfunction

  always_comb res = gates(a, b, xor_stuck);
  assign res2 = 7'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; the next edge is E0. Returns #1 after E0.
  task automatic run_start(input bit hold);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int c);
    c = 0;
    while (!(sel ? done2 : done) && c < int'(LIMIT)) begin
      tick();
      c++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " a"},    32'(a), 0);
    check({tag, " b"},    32'(b), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " pass"}, 32'(pass), 0);
    check({tag, " err"},  32'(errc), 0);
    check({tag, " ffv"},  32'(ffv), 0);
    check({tag, " ffm"},  32'(ffm), 0);
  endtask

  initial begin
    int c;
    tbl[0]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{2,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{3,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{4,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{5,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{6,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{7,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{9,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{10, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{11, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{12, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; xor_stuck = 1'b0;
    tick(); tick();
    check_zero("reset");
    check("reset dut2 busy", 32'(busy2), 0);
    check("reset dut2 err",  32'(errc2), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Correct gates; a second start at E0+4 must be ignored.
    run_start(1'b0);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      check($sformatf("t1 a c%0d", tbl[i].cyc),    32'(a),    32'(tbl[i].a));
      check($sformatf("t1 b c%0d", tbl[i].cyc),    32'(b),    32'(tbl[i].b));
      check($sformatf("t1 busy c%0d", tbl[i].cyc), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("t1 done c%0d", tbl[i].cyc), 32'(done), 32'(tbl[i].done));
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
    end
    check("t1 pass", 32'(pass), 1);
    check("t1 err",  32'(errc), 0);
    check("t1 ffv",  32'(ffv), 0);
    check("t1 ffm",  32'(ffm), 0);

    // XOR stuck at 0.
    xor_stuck = 1'b1;
    run_start(1'b0);
    check("t2 done cleared", 32'(done), 0);
    wait_done(1'b0, c);
`ifdef GATES_CHK_STOP_ON_FAIL_EN
    check("t2 done cycle", 32'(c), 6);
    check("t2 err", 32'(errc), 1);
    check("t2 a", 32'(a), 0);
    check("t2 b", 32'(b), 1);
`else
    check("t2 done cycle", 32'(c), 12);
    check("t2 err", 32'(errc), 2);
    check("t2 a", 32'(a), 1);
    check("t2 b", 32'(b), 1);
`endif
    check("t2 pass", 32'(pass), 0);
    check("t2 busy", 32'(busy), 0);
    check("t2 ffv",  32'(ffv), 32'h1);
    check("t2 ffm",  32'(ffm), 32'h20);

    // All-zero results, 100 passes, no settle time.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done(1'b1, c);
`ifdef GATES_CHK_STOP_ON_FAIL_EN
    check("t3 done cycle", 32'(c), 1);
    check("t3 err", 32'(errc2), 1);
`else
    check("t3 done cycle", 32'(c), 400);
    check("t3 err", 32'(errc2), 255);
    check("t3 a", 32'(a2), 1);
    check("t3 b", 32'(b2), 1);
`endif
    check("t3 pass", 32'(pass2), 0);
    check("t3 ffv",  32'(ffv2), 0);
    check("t3 ffm",  32'(ffm2), 32'h59);

    // Reset in the middle of a run.
    xor_stuck = 1'b0;
    run_start(1'b0);
    repeat (5) tick();
    check("t4 busy before reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("t4 mid-run reset");
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("t4 idle after reset", 32'(busy), 0);
    run_start(1'b0);
    wait_done(1'b0, c);
    check("t4 done cycle", 32'(c), 12);
    check("t4 pass", 32'(pass), 1);
    check("t4 err",  32'(errc), 0);

    // Start held high through DONE restarts at E0+13.
    run_start(1'b1);
    wait_done(1'b0, c);
    check("t5 done cycle", 32'(c), 12);
    tick();
    check("t5 restart done", 32'(done), 0);
    check("t5 restart busy", 32'(busy), 1);
    check("t5 restart a",    32'(a), 0);
    check("t5 restart b",    32'(b), 0);
    start = 1'b0;
    wait_done(1'b0, c);
    check("t5 second run done cycle", 32'(c), 12);
    check("t5 second run pass", 32'(pass), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gates_self_checker.md
# gates_self_checker

Sequential stimulus-and-check stage for the basic two-input gate set (NOT, AND, OR, NOR, NAND, XOR, XNOR). On a start pulse it drives the shared gate inputs `a_o`/`b_o` through the full truth table, waits a programmable settle time per vector, and compares the seven returned gate outputs against expected values. It reports pass/fail, an error count and first-failure diagnostics, replacing hand-read `$monitor` output with a synthesizable self-check.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling; legal range 0..15.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: run request; sampled only in IDLE or DONE.
- `a_o` input-side drive, output 1: operand A to all gates.
- `b_o` output 1: operand B to all gates.
- `res_i` input 7: gate results; bit 0 NOT(A), 1 AND, 2 OR, 3 NOR, 4 NAND, 5 XOR, 6 XNOR.
- `busy` output 1: run in progress.
- `done` output 1: run finished; level, held until the next accepted start or reset.
- `pass` output 1: valid when `done`=1; 1 iff `err_count`=0.
- `err_count` output 8: number of failing vector compares, saturating at 255.
- `first_fail_vec` output 2: {A,B} of the first failing compare.
- `first_fail_mask` output 7: XOR of expected and actual `res_i` at the first failing compare.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, `start`=1 at an edge: go to RUN. Clear `done`, `pass`, `err_count`, `first_fail_*`, vector index, pass counter and settle counter. Drive vector 00.
- Vector order per pass: {A,B} = 00, 01, 10, 11. Index is 2 bits, so `a_o` = idx[1] and `b_o` = idx[0]. The index wraps 11 -> 00 between passes.
- RUN: each vector is held for SETTLE_CYCLES+1 cycles. On the last edge of that window, `res_i` is compared with the expected vector `{~(a^b), a^b, ~(a&b), ~(a|b), a|b, a&b, ~a}`.
- Mismatch (any bit): `err_count` increments, saturating at 255. If it is the first mismatch of the run, latch `first_fail_vec` and `first_fail_mask`.
- After the compare of vector 11 on pass PASSES: go to DONE. Set `done`=1, `busy`=0, `pass`=(`err_count`==0, including that final compare). `a_o`/`b_o` hold 11.
- `start` in RUN is ignored.
- A `start` held high in DONE restarts the run on the next edge.

## Timing
- Reset values: `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_mask`=0. FSM goes to IDLE.
- Reset is effective immediately on `rst_n` low, including mid-run; there is no resumption.
- Let E0 be the edge where `start` is accepted. From E0: `busy`=1, `a_o`/`b_o`=00.
- Compares occur at edges E0 + k·(SETTLE_CYCLES+1), for k = 1 .. 4·PASSES. The vector changes at the same edge as each compare, except the final compare.
- `done` rises and `busy` falls at the final compare edge. Defaults: E0+12.
- All outputs are registered. There is no combinational path from `res_i` to any output.
- SETTLE_CYCLES=0: each vector is driven for exactly one cycle.

## Configuration
- `GATES_CHK_STOP_ON_FAIL_EN` defined: the first failing compare ends the run at that edge. Results are `done`=1, `busy`=0, `pass`=0, `err_count`=1, first-fail fields latched, and `a_o`/`b_o` hold the failing vector.
- `GATES_CHK_STOP_ON_FAIL_EN` undefined: all 4·PASSES vectors always run and every failure is counted.

## Test plan
- Correct gates, defaults, `start` pulse at E0 -> `a_o`/`b_o` = 00, 01, 10, 11, each held 3 cycles; `done`=1 at E0+12; `pass`=1; `err_count`=0.
- XOR output stuck at 0, macro undefined -> `err_count`=2, `first_fail_vec`=2'b01, `first_fail_mask`=7'h20, `pass`=0, `done` at E0+12.
- Same fault with `GATES_CHK_STOP_ON_FAIL_EN` defined -> `done`=1 at E0+6, `err_count`=1, `a_o`/`b_o` hold 01.
- `res_i` forced to 7'h00, PASSES=100, SETTLE_CYCLES=0 -> every vector fails, 400 compares; `err_count` saturates at 255; `done` at E0+400.
- `rst_n` pulsed low at E0+5 -> all outputs return to 0 immediately. A fresh `start` afterwards completes normally with `pass`=1.
- `start` reasserted at E0+4 -> ignored, `done` still at E0+12. `start` held high through DONE -> a new run begins at E0+13 with `done` cleared.
